bus_master_copy: RTL

//  Bus master that sits directly upstream of the single-master bus arbiter.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_master_dp.sv | 65 ++++++
 rtl/bus_master_copy.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the single-master bus: default widths and the 3-bit
// state encoding of the copy master. The arbiter and slave blocks import the
// same package, so the encoding values below must stay fixed.
// ----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_LAT  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } bus_state_t;

endpackage

// File: rtl/bus_master_dp.sv
// ----------------------------------------------------------------------------
// bus_master_dp
// Datapath of the copy master: source/destination address registers, the
// remaining-word counter and the read-data capture register.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   load                     latch load_src/load_dst/load_len (new command)
//   step                     commit one word: src+1, dst+1, cnt-1
//   capture                  latch cap_data into the data register
//   load_src/dst/len         operands of the accepted command
//   cap_data                 bus read data
//   src, dst, cnt, data      current register contents
// ----------------------------------------------------------------------------
module bus_master_dp
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic              capture,
    input  logic [ADDR_W-1:0] load_src,
    input  logic [ADDR_W-1:0] load_dst,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [DATA_W-1:0] cap_data,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  cnt,
    output logic [DATA_W-1:0] data
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);

    // Address increments wrap naturally at 2^ADDR_W; the counter is held at
    // zero so it can never underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src  <= '0;
            dst  <= '0;
            cnt  <= '0;
            data <= '0;
        end else begin
            if (load) begin
                src <= load_src;
                dst <= load_dst;
                cnt <= load_len;
            end else if (step) begin
                src <= src + ADDR_ONE;
                dst <= dst + ADDR_ONE;
                if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                end
            end
            if (capture) begin
                data <= cap_data;
            end
        end
    end

endmodule

// File: rtl/bus_master_copy.sv
// ----------------------------------------------------------------------------
// bus_master_copy
// Bus master that copies op_len words from op_src to op_dst over the shared
// bus. It requests the bus, waits for the registered grant, then runs a
// read / capture / write sequence per word (3 cycles per word) and pulses
// op_done when finished. Losing the grant mid-word restarts that word.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op_start                command strobe (only honoured in IDLE)
//   op_src, op_dst, op_len  command operands, latched on acceptance
//   op_busy                 command in progress (any state but IDLE)
//   op_done                 one-cycle completion pulse
//   m_req                   bus request to the arbiter
//   m_grant                 registered grant from the arbiter
//   m_addr, m_wr, m_dout    bus address, write strobe, write data
//   m_din                   bus read data (one cycle after the read address)
// ----------------------------------------------------------------------------
module bus_master_copy
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic [ADDR_W-1:0] op_src,
    input  logic [ADDR_W-1:0] op_dst,
    input  logic [LEN_W-1:0]  op_len,
    output logic              op_busy,
    output logic              op_done,
    output logic              m_req,
    input  logic              m_grant,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    bus_state_t        state;
    bus_state_t        state_next;
    logic              load;
    logic              step;
    logic              capture;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] data;

    bus_master_dp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_dp (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .step     (step),
        .capture  (capture),
        .load_src (op_src),
        .load_dst (op_dst),
        .load_len (op_len),
        .cap_data (m_din),
        .src      (src),
        .dst      (dst),
        .cnt      (cnt),
        .data     (data)
    );

    // Datapath strobes. A word is only captured/committed while the grant is
    // still held, so a grant loss leaves src/dst/cnt pointing at the same word.
    always_comb begin
        load    = (state == ST_IDLE) && op_start;
        capture = (state == ST_LAT) && m_grant;
        step    = (state == ST_WR) && m_grant;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (op_start) begin
                    state_next = (op_len != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (m_grant) begin
                    state_next = ST_RD;
                end
            end
            ST_RD:   state_next = m_grant ? ST_LAT : ST_REQ;
            ST_LAT:  state_next = m_grant ? ST_WR : ST_REQ;
            ST_WR: begin
                if (!m_grant) begin
                    state_next = ST_REQ;
                end else if (cnt == CNT_ONE) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RD;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state, so each one equals
    // a pure decode of the current state and has no path from the inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            m_wr    <= 1'b0;
            op_busy <= 1'b0;
            op_done <= 1'b0;
        end else begin
            state   <= state_next;
            m_req   <= (state_next == ST_REQ) || (state_next == ST_RD) ||
                       (state_next == ST_LAT) || (state_next == ST_WR);
            m_wr    <= (state_next == ST_WR);
            op_busy <= (state_next != ST_IDLE);
            op_done <= (state_next == ST_DONE);
        end
    end

    // Address and write data come straight from datapath registers, selected
    // by state; they read zero whenever the bus is not being addressed.
    always_comb begin
        m_addr = '0;
        m_dout = '0;
        if (state == ST_RD) begin
            m_addr = src;
        end else if (state == ST_WR) begin
            m_addr = dst;
            m_dout = data;
        end
    end

endmodule
